// File: rtl/rggen_apb_bridge.sv
// Bridges the rggen generic register-bus handshake onto an APB4 requester port.
// Each bus request becomes one SETUP/ACCESS transfer; every output comes straight from a flop.
module rggen_apb_bridge #(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          BUS_WIDTH     = 32,
  parameter logic [2:0]  PPROT         = 3'b000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bus_valid,
  input  logic [1:0]               i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
  input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
  output logic                     o_bus_ready,
  output logic [1:0]               o_bus_status,
  output logic [BUS_WIDTH-1:0]     o_bus_read_data,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  input  logic                     i_pready,
  input  logic                     i_pslverr,
  input  logic [BUS_WIDTH-1:0]     i_prdata
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETUP    = 2'd1;
  localparam logic [1:0] ACCESS   = 2'd2;
  localparam logic [1:0] RESPONSE = 2'd3;

  logic [1:0]               state_q,     state_d;
  logic                     psel_q,      psel_d;
  logic                     penable_q,   penable_d;
  logic                     pwrite_q,    pwrite_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q,     paddr_d;
  logic [STRB_WIDTH-1:0]    pstrb_q,     pstrb_d;
  logic [BUS_WIDTH-1:0]     pwdata_q,    pwdata_d;
  logic                     ready_q,     ready_d;
  logic [1:0]               status_q,    status_d;
  logic [BUS_WIDTH-1:0]     rdata_q,     rdata_d;

  // The non-posted flag is deliberately ignored: every write waits for PREADY.
  logic unused_access;
  assign unused_access = i_bus_access[1];

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pstrb_d   = pstrb_q;
    pwdata_d  = pwdata_q;
    ready_d   = 1'b0;
    status_d  = status_q;
    rdata_d   = rdata_q;

    case (state_q)
      IDLE: begin
        if (i_bus_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = i_bus_access[0];
          paddr_d  = i_bus_address;
          pstrb_d  = i_bus_access[0] ? i_bus_strobe     : '0;
          pwdata_d = i_bus_access[0] ? i_bus_write_data : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Completer response is only meaningful with PENABLE and PREADY both high.
        if (i_pready) begin
          state_d   = RESPONSE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          status_d  = {i_pslverr, 1'b0};
          rdata_d   = pwrite_q ? '0 : i_prdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pstrb_q   <= '0;
      pwdata_q  <= '0;
      ready_q   <= 1'b0;
      status_q  <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pstrb_q   <= pstrb_d;
      pwdata_q  <= pwdata_d;
      ready_q   <= ready_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_psel          = psel_q;
  assign o_penable       = penable_q;
  assign o_pwrite        = pwrite_q;
  assign o_paddr         = paddr_q;
  assign o_pprot         = PPROT;
  assign o_pstrb         = pstrb_q;
  assign o_pwdata        = pwdata_q;
  assign o_bus_ready     = ready_q;
  assign o_bus_status    = status_q;
  assign o_bus_read_data = rdata_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Randomized self-checking bench for rggen_apb_bridge with a transaction-level APB completer model.
module tb_rggen_apb_bridge;

  logic        clk;
  logic        rstN;
  logic        busValid;
  logic [1:0]  busAccess;
  logic [7:0]  busAddress;
  logic [31:0] busWriteData;
  logic [3:0]  busStrobe;
  logic        busReady;
  logic [1:0]  busStatus;
  logic [31:0] busReadData;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int errCount   = 0;
  int checkCount = 0;

  // Values the bus side should be left holding after the most recent completed transfer.
  logic [7:0]  lastAddr   = 8'h00;
  logic [1:0]  lastStatus = 2'b00;
  logic [31:0] lastRdata  = 32'h0;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (8),
    .BUS_WIDTH     (32),
    .PPROT         (3'b000)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .i_bus_valid      (busValid),
    .i_bus_access     (busAccess),
    .i_bus_address    (busAddress),
    .i_bus_write_data (busWriteData),
    .i_bus_strobe     (busStrobe),
    .o_bus_ready      (busReady),
    .o_bus_status     (busStatus),
    .o_bus_read_data  (busReadData),
    .o_psel           (psel),
    .o_penable        (penable),
    .o_pwrite         (pwrite),
    .o_paddr          (paddr),
    .o_pprot          (pprot),
    .o_pstrb          (pstrb),
    .o_pwdata         (pwdata),
    .i_pready         (pready),
    .i_pslverr        (pslverr),
    .i_prdata         (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One generic-bus access. Caller is 1ns past a clock edge, either in an IDLE cycle
  // or (afterResponse) in the RESPONSE cycle of the previous access with valid kept high.
  task automatic applyStimulus(input logic [7:0] addr, input logic [1:0] acc,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int waits, input logic err, input logic [31:0] rdata,
                               input bit afterResponse);
    logic        isWrite;
    logic [31:0] expPwdata;
    logic [3:0]  expPstrb;
    logic [31:0] expRdata;
    isWrite   = acc[0];
    expPwdata = isWrite ? wdata : 32'h0;
    expPstrb  = isWrite ? strb  : 4'h0;
    expRdata  = isWrite ? 32'h0 : rdata;

    busValid     = 1'b1;
    busAccess    = acc;
    busAddress   = addr;
    busWriteData = wdata;
    busStrobe    = strb;

    if (afterResponse) begin
      @(posedge clk); #1;
      checkOutput("gapPsel",  psel,     1'b0);
      checkOutput("gapReady", busReady, 1'b0);
    end

    @(posedge clk); #1;
    checkOutput("setupPsel",    psel,     1'b1);
    checkOutput("setupPenable", penable,  1'b0);
    checkOutput("setupPaddr",   paddr,    addr);
    checkOutput("setupPwrite",  pwrite,   isWrite);
    checkOutput("setupPwdata",  pwdata,   expPwdata);
    checkOutput("setupPstrb",   pstrb,    expPstrb);
    checkOutput("setupReady",   busReady, 1'b0);

    @(posedge clk); #1;
    for (int w = 0; w <= waits; w++) begin
      checkOutput("accPsel",    psel,     1'b1);
      checkOutput("accPenable", penable,  1'b1);
      checkOutput("accPaddr",   paddr,    addr);
      checkOutput("accPwrite",  pwrite,   isWrite);
      checkOutput("accPwdata",  pwdata,   expPwdata);
      checkOutput("accPstrb",   pstrb,    expPstrb);
      checkOutput("accPprot",   pprot,    3'b000);
      checkOutput("accReady",   busReady, 1'b0);
      if (w == waits) begin
        pready  = 1'b1;
        pslverr = err;
        prdata  = rdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      @(posedge clk); #1;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;

    checkOutput("respReady",   busReady,    1'b1);
    checkOutput("respStatus",  busStatus,   err ? 2'b10 : 2'b00);
    checkOutput("respRdata",   busReadData, expRdata);
    checkOutput("respPsel",    psel,        1'b0);
    checkOutput("respPenable", penable,     1'b0);
    busValid   = 1'b0;
    lastAddr   = addr;
    lastStatus = err ? 2'b10 : 2'b00;
    lastRdata  = expRdata;
  endtask

  // Idle cycle after a response: ready must be a single pulse and bus/APB fields must hold.
  task automatic idleCycle();
    @(posedge clk); #1;
    checkOutput("idleReady",  busReady,    1'b0);
    checkOutput("idlePsel",   psel,        1'b0);
    checkOutput("idlePaddr",  paddr,       lastAddr);
    checkOutput("idleStatus", busStatus,   lastStatus);
    checkOutput("idleRdata",  busReadData, lastRdata);
  endtask

  initial begin
    rstN         = 1'b0;
    busValid     = 1'b0;
    busAccess    = 2'b00;
    busAddress   = 8'h00;
    busWriteData = 32'h0;
    busStrobe    = 4'h0;
    pready       = 1'b0;
    pslverr      = 1'b0;
    prdata       = 32'h0;

    #12;
    checkOutput("rstPsel",    psel,        1'b0);
    checkOutput("rstPenable", penable,     1'b0);
    checkOutput("rstPwrite",  pwrite,      1'b0);
    checkOutput("rstReady",   busReady,    1'b0);
    checkOutput("rstPaddr",   paddr,       8'h00);
    checkOutput("rstPstrb",   pstrb,       4'h0);
    checkOutput("rstPwdata",  pwdata,      32'h0);
    checkOutput("rstRdata",   busReadData, 32'h0);
    checkOutput("rstStatus",  busStatus,   2'b00);
    checkOutput("rstPprot",   pprot,       3'b000);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    applyStimulus(8'h10, 2'b10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    idleCycle();
    applyStimulus(8'h24, 2'b11, 32'h12345678, 4'b0101, 3, 1'b0, 32'hCAFEF00D, 1'b0);
    idleCycle();
    applyStimulus(8'h30, 2'b00, 32'h0, 4'h0, 1, 1'b1, 32'h55AA55AA, 1'b0);
    idleCycle();
    applyStimulus(8'h34, 2'b00, 32'h0, 4'h0, 0, 1'b0, 32'h01020304, 1'b0);
    applyStimulus(8'h38, 2'b01, 32'hA5A5A5A5, 4'hF, 2, 1'b0, 32'h0, 1'b1);
    idleCycle();
    applyStimulus(8'h3C, 2'b11, 32'hA5A5A5A5, 4'hF, 2, 1'b0, 32'h0, 1'b0);
    idleCycle();

    // Reset in the middle of an ACCESS phase with the completer stalling
    busValid   = 1'b1;
    busAccess  = 2'b00;
    busAddress = 8'h44;
    pready     = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("preRstPenable", penable, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncPsel",    psel,        1'b0);
    checkOutput("asyncPenable", penable,     1'b0);
    checkOutput("asyncPaddr",   paddr,       8'h00);
    checkOutput("asyncStatus",  busStatus,   2'b00);
    checkOutput("asyncRdata",   busReadData, 32'h0);
    busValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("inRstReady", busReady, 1'b0);
    end
    @(negedge clk);
    rstN = 1'b1;
    lastAddr   = 8'h00;
    lastStatus = 2'b00;
    lastRdata  = 32'h0;
    @(posedge clk); #1;
    checkOutput("postRstReady", busReady, 1'b0);
    applyStimulus(8'h48, 2'b10, 32'h0, 4'h0, 1, 1'b0, 32'h87654321, 1'b0);
    idleCycle();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      bit b2b;
      b2b = (n > 0) && ($urandom_range(0, 2) == 0);
      if (!b2b && n > 0) idleCycle();
      applyStimulus(8'($urandom), 2'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), 1'($urandom), $urandom, b2b);
    end
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
